// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: valid/ready handshake, 2-entry skid, sync flush.
// Optional stall/bubble counter output enabled by defining PIPE_STAGE_BUBBLE_CNT_EN.
module pipe_stage_elastic #(
  parameter int          PAY_W    = 97,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic [PAY_W-1:0] in_pay,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [PAY_W-1:0] out_pay
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  ,
  output logic [31:0]      bubble_cnt
`endif
);

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [PAY_W-1:0] pay;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam entry_t RST_ENTRY = '{instr: '0, pc: RESET_PC, pay: '0};

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{instr: in_instr, pc: in_pc, pay: in_pay};

  // Both handshake outputs come straight from the state register, so there is
  // no combinational path from out_ready back to in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;
  assign out_pay   = main_q.pay;

  // NOTE: the two data registers are reset too, because a flushed or reset
  // stage must present instr=0 (a nop) and RESET_PC on its outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples pre-edge values regardless of statement order.
      state  <= EMPTY;
      main_q <= RST_ENTRY;
      skid_q <= RST_ENTRY;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= RST_ENTRY;
      skid_q <= RST_ENTRY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_entry;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_entry;
          end else if (in_fire) begin
            skid_q <= in_entry;
            state  <= FULL;
          end else if (out_fire) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  // Counts every cycle the stage does not hand an entry downstream; flush does not clear it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt <= '0;
    end else if (!out_fire && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: the reference is a depth-2 FIFO queue,
// checked every cycle by a separate monitor process.
module tb_pipe_stage_elastic;

  localparam int          PAY_W    = 97;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef struct {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [PAY_W-1:0] pay;
  } item_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [31:0]      in_pc = '0;
  logic [PAY_W-1:0] in_pay = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [PAY_W-1:0] out_pay;
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  logic [31:0]      bubble_cnt;
  logic [31:0]      bubble_model = '0;
`endif

  item_t q[$];
  bit    cleared = 1'b1;
  int    n_vec = 0;
  int    n_err = 0;

  pipe_stage_elastic #(.PAY_W(PAY_W), .RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_pay    (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_pay   (out_pay)
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model learns what was accepted or squashed at the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    item_t it;
    bit    fire;
    it.pc    = pc;
    it.instr = $urandom;
    for (int i = 0; i < PAY_W; i++) it.pay[i] = 1'($urandom_range(0, 1));
    in_valid  = v;
    in_pc     = it.pc;
    in_instr  = it.instr;
    in_pay    = it.pay;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    fire = in_valid && in_ready;
    @(posedge clk);
    if (fl) begin
      q.delete();
      cleared = 1'b1;
    end else if (fire) begin
      q.push_back(it);
      cleared = 1'b0;
    end
    #1;
  endtask

  // Monitor: expected occupancy, head entry and counter come only from the model.
  always @(negedge clk) begin
    if (reset_n) begin
      check("out_valid", 128'(out_valid), 128'(q.size() != 0));
      check("in_ready", 128'(in_ready), 128'(q.size() < 2));
      if (q.size() != 0 && out_valid) begin
        check("out_instr", 128'(out_instr), 128'(q[0].instr));
        check("out_pc", 128'(out_pc), 128'(q[0].pc));
        check("out_pay", 128'(out_pay), 128'(q[0].pay));
        if (out_ready) void'(q.pop_front());
      end else if (q.size() == 0 && cleared) begin
        check("idle_instr", 128'(out_instr), 128'(0));
        check("idle_pc", 128'(out_pc), 128'(RESET_PC));
      end
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
      check("bubble_cnt", 128'(bubble_cnt), 128'(bubble_model));
      if (!(out_valid && out_ready) && bubble_model != 32'hFFFF_FFFF) bubble_model++;
    end else begin
      bubble_model = '0;
`endif
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_pc", 128'(out_pc), 128'(RESET_PC));
    check("rst_out_instr", 128'(out_instr), 128'(0));
    @(posedge clk);
    #1;

    // idle then stall cycles for the bubble counter, then streaming
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

    // backpressure into the skid, ignored third offer, then drain
    step(1'b1, 32'h3000, 1'b0, 1'b0);
    step(1'b1, 32'h3004, 1'b0, 1'b0);
    step(1'b1, 32'h3008, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);

    // flush while FULL with a same-cycle offer of pc 3010
    step(1'b1, 32'h3000, 1'b0, 1'b0);
    step(1'b1, 32'h3004, 1'b0, 1'b0);
    step(1'b1, 32'h3010, 1'b0, 1'b1);
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_out_pc", 128'(out_pc), 128'(RESET_PC));
    check("flush_out_instr", 128'(out_instr), 128'(0));
    // flush while ONE with a same-cycle accepted input and out_fire
    step(1'b1, 32'h3020, 1'b0, 1'b0);
    step(1'b1, 32'h3024, 1'b1, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);

    // asynchronous reset between edges while FULL
    step(1'b1, 32'h3100, 1'b0, 1'b0);
    step(1'b1, 32'h3104, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    q.delete();
    cleared = 1'b1;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(1));
    check("arst_out_pc", 128'(out_pc), 128'(RESET_PC));
    check("arst_out_instr", 128'(out_instr), 128'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 1) != 0,
           $urandom_range(0, 15) == 0);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Next-generation inter-stage pipeline register for the 5-stage MIPS core. It replaces the fixed-width, WE-gated per-stage registers.
- Carries instr, pc and a parametrised payload bundle (ALU result, DM data, MDU result, flags) between stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so ready is registered and full throughput is kept.
- Supports synchronous flush for branch/exception squash, and a configurable reset PC.

Parameters:
- PAY_W, 97, payload width in bits (default = 3x32 data + 1 flag bit).
- RESET_PC, 32'h0000_3000, value driven on out_pc after reset or flush.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held entries and of any same-cycle input.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; driven from state register only.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction PC.
- in_pay  in  PAY_W  payload bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- out_pay  out  PAY_W  head payload.

Behaviour:
- Clock and reset: one clock domain `clk`; reset is asynchronous, active-low, `reset_n`.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: main register M (drives out_*) and skid register S. State is EMPTY, ONE or FULL.
- Reset (reset_n=0, asynchronous):
  - state EMPTY, out_valid=0, in_ready=1.
  - M and S: instr=0, pc=RESET_PC, pay=0.
- Outputs:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - out_* = M. No combinational path from out_ready to in_ready.
- Transitions (flush=0):
  - EMPTY: in_fire -> load M, go to ONE. Otherwise hold.
  - ONE, in_fire & out_fire: load M with the input, stay ONE (back-to-back, 1 entry/cycle).
  - ONE, in_fire & !out_fire: load S, go to FULL.
  - ONE, !in_fire & out_fire: go to EMPTY. M contents are retained (don't-care).
  - ONE, neither event: hold.
  - FULL: in_fire is impossible (in_ready=0). On out_fire, M<=S and go to ONE. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Ordering is strictly FIFO.
- Flush (highest priority below reset):
  - Next state is EMPTY.
  - M and S are cleared to reset values (out_instr=0 acts as nop, out_pc=RESET_PC).
  - A same-cycle in_valid is dropped. A same-cycle out_fire counts as consumed downstream.
- Holding: while out_valid=1 and out_ready=0, out_* are stable cycle to cycle.
- Input rule: in_* are sampled only on in_fire. Values present while in_ready=0 are ignored.
- Width rules: no arithmetic. Payload is bit-exact.
- Reset asserted mid-transfer: all entries are lost immediately, with no clock needed.

Optional Feature:
- Macro: PIPE_STAGE_BUBBLE_CNT_EN.
- Defined:
  - Adds output port bubble_cnt (32).
  - Increments each cycle where out_valid=0, or out_valid=1 & out_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset_n only; flush does not clear it.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release: reset_n low then high -> out_valid=0, in_ready=1, out_pc=32'h0000_3000, out_instr=0.
- Streaming: in_valid=1 and out_ready=1 for 4 cycles, pc 3000/3004/3008/300C -> same pcs on out_pc in order, one per cycle, 1-cycle latency, in_ready never 0.
- Backpressure and skid:
  - Send pc 3000, 3004 with out_ready=0 -> in_ready=0 after the second accept; out_pc=3000 held stable.
  - Raise out_ready -> 3000 then 3004 delivered, in_ready back to 1.
- Flush in FULL state plus same-cycle input: flush=1 with in_valid=1 (pc 3010) -> next cycle out_valid=0, out_instr=0, out_pc=3000; pc 3010 never appears.
- Async reset mid-stream: pull reset_n low between clock edges while FULL -> outputs reset immediately; after release, no stale entry emerges.
- Bubble count (with PIPE_STAGE_BUBBLE_CNT_EN): 3 idle cycles then 2 stall cycles -> bubble_cnt=5; flush leaves it 5.
